// File: rtl/spi_byte_engine.sv
// SPI mode-0 byte engine for the NVM link: MSB-first, full duplex.
// The upstream divider rollover strobe (tick) is the half-SCK timebase;
// each tick advances the FSM by one half bit period.
module spi_byte_engine #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 4
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              tick,
  output logic              count_en,
  output logic              count_clear,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_keep_cs,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy,
  output logic              sck,
  output logic              mosi,
  input  logic              miso,
  output logic              cs_n
);

  typedef enum logic [2:0] {
    IDLE,
    LEAD,
    SHIFT_LO,
    SHIFT_HI,
    TRAIL
  } state_t;

  state_t              state_q, state_d;
  logic                sck_q, sck_d;
  logic                mosi_q, mosi_d;
  logic                cs_n_q, cs_n_d;
  logic                rx_valid_q, rx_valid_d;
  logic                keep_q, keep_d;
  logic [CNT_W-1:0]    bit_idx_q, bit_idx_d;
  logic [DATA_W-1:0]   tx_shreg_q, tx_shreg_d;
  logic [DATA_W-1:0]   rx_shreg_q, rx_shreg_d;
  logic [DATA_W-1:0]   rx_data_q, rx_data_d;

  // State and datapath registers; reset aborts any transfer and raises cs_n at once
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q    <= IDLE;
      sck_q      <= 1'b0;
      mosi_q     <= 1'b0;
      cs_n_q     <= 1'b1;
      rx_valid_q <= 1'b0;
      keep_q     <= 1'b0;
      bit_idx_q  <= '0;
      tx_shreg_q <= '0;
      rx_shreg_q <= '0;
      rx_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      sck_q      <= sck_d;
      mosi_q     <= mosi_d;
      cs_n_q     <= cs_n_d;
      rx_valid_q <= rx_valid_d;
      keep_q     <= keep_d;
      bit_idx_q  <= bit_idx_d;
      tx_shreg_q <= tx_shreg_d;
      rx_shreg_q <= rx_shreg_d;
      rx_data_q  <= rx_data_d;
    end
  end

  // Next-state logic: everything holds unless a handshake or a tick moves it
  always_comb begin
    state_d    = state_q;
    sck_d      = sck_q;
    mosi_d     = mosi_q;
    cs_n_d     = cs_n_q;
    rx_valid_d = 1'b0;
    keep_d     = keep_q;
    bit_idx_d  = bit_idx_q;
    tx_shreg_d = tx_shreg_q;
    rx_shreg_d = rx_shreg_q;
    rx_data_d  = rx_data_q;

    case (state_q)
      IDLE: begin
        if (tx_valid) begin
          tx_shreg_d = tx_data;
          keep_d     = tx_keep_cs;
          cs_n_d     = 1'b0;
          mosi_d     = tx_data[DATA_W-1];
          bit_idx_d  = CNT_W'(DATA_W - 1);
          state_d    = LEAD;
        end
      end
      LEAD, SHIFT_LO: begin
        if (tick) begin
          sck_d      = 1'b1;
          rx_shreg_d = {rx_shreg_q[DATA_W-2:0], miso};
          state_d    = SHIFT_HI;
        end
      end
      SHIFT_HI: begin
        if (tick) begin
          sck_d = 1'b0;
          if (bit_idx_q == '0) begin
            state_d = TRAIL;
          end else begin
            bit_idx_d  = bit_idx_q - CNT_W'(1);
            tx_shreg_d = {tx_shreg_q[DATA_W-2:0], tx_shreg_q[DATA_W-1]};
            mosi_d     = tx_shreg_q[DATA_W-2];
            state_d    = SHIFT_LO;
          end
        end
      end
      TRAIL: begin
        if (tick) begin
          rx_data_d  = rx_shreg_q;
          rx_valid_d = 1'b1;
          cs_n_d     = ~keep_q;
          state_d    = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign tx_ready    = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign count_en    = (state_q != IDLE);
  assign count_clear = (state_q == IDLE);
  assign sck         = sck_q;
  assign mosi        = mosi_q;
  assign cs_n        = cs_n_q;
  assign rx_valid    = rx_valid_q;
  assign rx_data     = rx_data_q;

endmodule

// File: tb/tb_spi_byte_engine.sv
// Self-checking bench for spi_byte_engine: table-driven transfers, corner-case
// sequences (back-to-back, tick stall, mid-transfer reset) and random transfers
// against a byte-level reference of what an SPI slave should see and return.
module tb_spi_byte_engine;

  logic       CLK = 1'b0;
  logic       nRST = 1'b0;
  logic       tick = 1'b0;
  logic       count_en, count_clear;
  logic [7:0] txData = 8'h00;
  logic       txKeepCs = 1'b0;
  logic       txValid = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, busy, sck, mosi, miso, cs_n;

  int checks = 0;
  int errors = 0;

  int   tickPeriod = 4;
  logic tickStall = 1'b0;
  int   tickCnt = 0;

  logic       loopback = 1'b1;
  logic [7:0] slaveByte = 8'h00;
  logic       slaveBit;

  int   totalRises = 0, xferRises = 0, csLowTicks = 0, rxPulses = 0, csRises = 0;
  int   mosiViol = 0, pulseViol = 0, ctrlViol = 0;
  logic prevSck = 1'b0, prevMosi = 1'b0, prevBusy = 1'b0, prevRxValid = 1'b0, prevCsn = 1'b1;
  logic mosiLog[$];

  int startRises, startLog, startTicks, startPulses, startCsRises;

  spi_byte_engine #(.DATA_W(8), .CNT_W(4)) dut (
    .CLK(CLK), .nRST(nRST), .tick(tick),
    .count_en(count_en), .count_clear(count_clear),
    .tx_data(txData), .tx_keep_cs(txKeepCs), .tx_valid(txValid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy),
    .sck(sck), .mosi(mosi), .miso(miso), .cs_n(cs_n)
  );

  always #5 CLK = ~CLK;

  // Slave model: presents its byte MSB first, one bit per SCK rise already seen
  assign slaveBit = (xferRises < 8) ? slaveByte[3'(7 - xferRises)] : 1'b0;
  assign miso = loopback ? mosi : slaveBit;

  // Divider stand-in: one-cycle tick every tickPeriod clocks unless stalled
  initial begin
    forever begin
      @(posedge CLK);
      #1;
      tickCnt++;
      tick = !tickStall && (tickCnt % tickPeriod == 0);
    end
  end

  // Bus monitor sampled mid-cycle: SCK rises, MOSI bits, CS-low ticks, pulses, control rules
  always @(negedge CLK) begin
    if (nRST) begin
      if (busy && !prevBusy) xferRises = 0;
      if (sck && !prevSck) begin
        totalRises++;
        xferRises++;
        mosiLog.push_back(mosi);
      end
      if (sck && prevSck && (mosi != prevMosi)) mosiViol++;
      if (tick && !cs_n) csLowTicks++;
      if (rx_valid) rxPulses++;
      if (rx_valid && prevRxValid) pulseViol++;
      if (cs_n && !prevCsn) csRises++;
      if ((count_en != busy) || (count_clear != !busy) || (tx_ready != !busy)) ctrlViol++;
    end
    prevSck     = sck;
    prevMosi    = mosi;
    prevBusy    = busy;
    prevRxValid = rx_valid;
    prevCsn     = cs_n;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Offer one byte and hold tx_valid until the engine accepts it
  task automatic applyStimulus(input logic [7:0] d, input logic k, input logic lb, input logic [7:0] sb);
    int n;
    @(negedge CLK);
    loopback  = lb;
    slaveByte = sb;
    txData    = d;
    txKeepCs  = k;
    txValid   = 1'b1;
    n = 0;
    while (!tx_ready && n < 2000) begin
      @(negedge CLK);
      n++;
    end
    checkOutput("accept tx_ready", tx_ready, 1);
    @(negedge CLK);
    txValid  = 1'b0;
    txData   = 8'($urandom);
    txKeepCs = 1'($urandom);
  endtask

  task automatic waitRx(input string tag, output logic [7:0] got);
    int n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!rx_valid && n < 2000);
    checkOutput({tag, " rx_valid seen"}, rx_valid, 1);
    got = rx_data;
  endtask

  task automatic startXfer(input logic [7:0] tx, input logic keep, input logic lb, input logic [7:0] sb);
    startRises  = totalRises;
    startLog    = mosiLog.size();
    startTicks  = csLowTicks;
    startPulses = rxPulses;
    applyStimulus(tx, keep, lb, sb);
  endtask

  task automatic finishXfer(input string tag, input logic [7:0] tx, input logic [7:0] expRx);
    logic [7:0] got;
    logic [7:0] sent;
    waitRx(tag, got);
    repeat (2) @(negedge CLK);
    checkOutput({tag, " rx_data"}, got, expRx);
    checkOutput({tag, " sck rises"}, totalRises - startRises, 8);
    checkOutput({tag, " cs_n low ticks"}, csLowTicks - startTicks, 17);
    checkOutput({tag, " rx_valid pulses"}, rxPulses - startPulses, 1);
    sent = 8'h00;
    if (mosiLog.size() >= startLog + 8)
      for (int i = 0; i < 8; i++) sent = {sent[6:0], mosiLog[startLog + i]};
    checkOutput({tag, " mosi bits"}, sent, tx);
  endtask

  task automatic runTransfer(input string tag, input logic [7:0] tx, input logic lb, input logic [7:0] sb, input logic [7:0] expRx);
    startXfer(tx, 1'b0, lb, sb);
    finishXfer(tag, tx, expRx);
  endtask

  typedef struct {
    logic [7:0] tx;
    logic       lb;
    logic [7:0] sb;
    logic [7:0] expRx;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic [7:0] got;
    logic [7:0] snapRx;
    logic [15:0] sent16;
    logic snapSck, snapMosi, snapCsn, snapBusy;
    int n, changes, pulsesAtReset;

    vecs[0] = '{tx: 8'hA5, lb: 1'b1, sb: 8'h00, expRx: 8'hA5};
    vecs[1] = '{tx: 8'hFF, lb: 1'b0, sb: 8'h3C, expRx: 8'h3C};
    vecs[2] = '{tx: 8'h00, lb: 1'b0, sb: 8'hFF, expRx: 8'hFF};
    vecs[3] = '{tx: 8'h81, lb: 1'b1, sb: 8'h00, expRx: 8'h81};
    vecs[4] = '{tx: 8'h4E, lb: 1'b0, sb: 8'hB1, expRx: 8'hB1};

    // Reset state
    #12;
    checkOutput("reset cs_n", cs_n, 1);
    checkOutput("reset sck", sck, 0);
    checkOutput("reset mosi", mosi, 0);
    checkOutput("reset rx_data", rx_data, 0);
    checkOutput("reset rx_valid", rx_valid, 0);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset tx_ready", tx_ready, 1);
    checkOutput("reset count_clear", count_clear, 1);
    checkOutput("reset count_en", count_en, 0);
    @(negedge CLK);
    nRST = 1'b1;
    repeat (3) @(negedge CLK);

    // Table-driven single-byte transfers
    for (int i = 0; i < 5; i++)
      runTransfer($sformatf("vec%0d", i), vecs[i].tx, vecs[i].lb, vecs[i].sb, vecs[i].expRx);

    // Back-to-back: 0x9F with keep_cs then 0x00, tx_valid held through completion
    startRises   = totalRises;
    startLog     = mosiLog.size();
    startTicks   = csLowTicks;
    startPulses  = rxPulses;
    startCsRises = csRises;
    @(negedge CLK);
    loopback = 1'b1;
    txData   = 8'h9F;
    txKeepCs = 1'b1;
    txValid  = 1'b1;
    n = 0;
    do begin @(negedge CLK); n++; end while (!busy && n < 100);
    checkOutput("b2b first accept", busy, 1);
    txData   = 8'h00;
    txKeepCs = 1'b0;
    waitRx("b2b first", got);
    checkOutput("b2b first rx_data", got, 8'h9F);
    checkOutput("b2b gap cs_n", cs_n, 0);
    checkOutput("b2b gap tx_ready", tx_ready, 1);
    checkOutput("b2b gap count_clear", count_clear, 1);
    checkOutput("b2b gap count_en", count_en, 0);
    @(negedge CLK);
    checkOutput("b2b second busy", busy, 1);
    checkOutput("b2b second count_en", count_en, 1);
    checkOutput("b2b second cs_n", cs_n, 0);
    checkOutput("b2b rx_data holds", rx_data, 8'h9F);
    txValid = 1'b0;
    waitRx("b2b second", got);
    repeat (2) @(negedge CLK);
    checkOutput("b2b second rx_data", got, 8'h00);
    checkOutput("b2b sck rises", totalRises - startRises, 16);
    checkOutput("b2b cs_n low ticks", csLowTicks - startTicks, 34);
    checkOutput("b2b rx_valid pulses", rxPulses - startPulses, 2);
    checkOutput("b2b cs_n rises", csRises - startCsRises, 1);
    sent16 = 16'h0000;
    if (mosiLog.size() >= startLog + 16)
      for (int i = 0; i < 16; i++) sent16 = {sent16[14:0], mosiLog[startLog + i]};
    checkOutput("b2b mosi bits", sent16, 16'h9F00);

    // Tick stall for 50 cycles while SCK is high
    startXfer(8'hC3, 1'b0, 1'b0, 8'h96);
    n = 0;
    do begin @(negedge CLK); n++; end while (!(xferRises == 3 && sck && !tick) && n < 500);
    checkOutput("stall reached SHIFT_HI", sck, 1);
    tickStall = 1'b1;
    snapSck  = sck;
    snapMosi = mosi;
    snapCsn  = cs_n;
    snapBusy = busy;
    snapRx   = rx_data;
    changes  = 0;
    repeat (50) begin
      @(negedge CLK);
      if (sck != snapSck || mosi != snapMosi || cs_n != snapCsn || busy != snapBusy) changes++;
    end
    checkOutput("stall frozen outputs", changes, 0);
    checkOutput("stall rx_data holds", rx_data, snapRx);
    tickStall = 1'b0;
    finishXfer("stall", 8'hC3, 8'h96);

    // Reset pulse during bit 4, then a clean transfer
    startXfer(8'hE7, 1'b0, 1'b1, 8'h00);
    n = 0;
    do begin @(negedge CLK); n++; end while (!(xferRises == 4 && !sck) && n < 500);
    pulsesAtReset = rxPulses;
    nRST = 1'b0;
    #1;
    checkOutput("abort cs_n", cs_n, 1);
    checkOutput("abort sck", sck, 0);
    checkOutput("abort busy", busy, 0);
    checkOutput("abort tx_ready", tx_ready, 1);
    checkOutput("abort rx_data", rx_data, 0);
    @(negedge CLK);
    nRST = 1'b1;
    repeat (40) @(negedge CLK);
    checkOutput("abort no rx_valid", rxPulses - pulsesAtReset, 0);
    runTransfer("after reset", 8'h5A, 1'b1, 8'h00, 8'h5A);

    // Random transfers against the byte-level slave/loopback reference
    for (int i = 0; i < 16; i++) begin
      logic [7:0] tx, sb;
      logic lb;
      tickPeriod = $urandom_range(1, 5);
      tx = 8'($urandom);
      sb = 8'($urandom);
      lb = 1'($urandom_range(0, 1));
      runTransfer($sformatf("rand%0d", i), tx, lb, sb, lb ? tx : sb);
    end

    checkOutput("mosi changed while sck high", mosiViol, 0);
    checkOutput("rx_valid wider than one cycle", pulseViol, 0);
    checkOutput("count_en/count_clear/tx_ready vs busy", ctrlViol, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
